// File: rtl/zba_issue_if.sv
// Issue-stage bus. The master side is the upstream/writeback/execute environment.
// The slave side is the issue stage.
interface zba_issue_if #(parameter int XLEN = 64);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1_val;
  logic [XLEN-1:0] out_rs2_val;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_rs1_val, out_rs2_val, out_funct3, out_rd,
           out_pc, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_rs1_val, out_rs2_val, out_funct3, out_rd,
           out_pc, out_illegal
  );
endinterface

// File: rtl/zba_issue_stage.sv
// Decode/operand-fetch stage for Zba sh1add/sh2add/sh3add.
// Holds one instruction in a single issue register, with stall-time operand refresh.
module zba_issue_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  zba_issue_if.slave   bus
);
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] F7_ZBA  = 7'b0010000;

  logic [XLEN-1:0] r_rf [NREGS];
  logic            r_valid;
  logic [XLEN-1:0] r_rs1_val, r_rs2_val, r_pc;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd, r_rs1_idx, r_rs2_idx;
  logic            r_illegal;

  logic [6:0]      w_opcode, w_funct7;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [2:0]      w_funct3;
  logic            w_legal, w_wb_wr, w_accept, w_stall;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;

  assign w_opcode = bus.in_instr[6:0];
  assign w_rd     = bus.in_instr[11:7];
  assign w_funct3 = bus.in_instr[14:12];
  assign w_rs1    = bus.in_instr[19:15];
  assign w_rs2    = bus.in_instr[24:20];
  assign w_funct7 = bus.in_instr[31:25];

  assign w_legal = (w_opcode == OP_REG) && (w_funct7 == F7_ZBA) &&
                   (w_funct3 == 3'b010 || w_funct3 == 3'b100 || w_funct3 == 3'b110);

  assign w_wb_wr  = bus.wb_en && (bus.wb_rd != 5'd0);
  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_stall  = r_valid && !bus.out_ready;

  // Writeback in the same cycle wins over the stale array value.
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 :
                     (w_wb_wr && bus.wb_rd == w_rs1) ? bus.wb_data : r_rf[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 :
                     (w_wb_wr && bus.wb_rd == w_rs2) ? bus.wb_data : r_rf[w_rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (w_wb_wr) begin
      r_rf[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_rs1_val <= '0;
      r_rs2_val <= '0;
      r_pc      <= '0;
      r_funct3  <= '0;
      r_rd      <= '0;
      r_rs1_idx <= '0;
      r_rs2_idx <= '0;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_rs1_val <= w_rs1_val;
      r_rs2_val <= w_rs2_val;
      r_pc      <= bus.in_pc;
      r_funct3  <= w_funct3;
      r_rd      <= w_rd;
      r_rs1_idx <= w_rs1;
      r_rs2_idx <= w_rs2;
      r_illegal <= !w_legal;
    end else if (w_stall) begin
      // Held operands track writebacks so the execute unit never sees stale data.
      if (w_wb_wr && bus.wb_rd == r_rs1_idx) r_rs1_val <= bus.wb_data;
      if (w_wb_wr && bus.wb_rd == r_rs2_idx) r_rs2_val <= bus.wb_data;
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = !r_valid || bus.out_ready;
  assign bus.out_valid   = r_valid;
  assign bus.out_rs1_val = r_rs1_val;
  assign bus.out_rs2_val = r_rs2_val;
  assign bus.out_funct3  = r_funct3;
  assign bus.out_rd      = r_rd;
  assign bus.out_pc      = r_pc;
  assign bus.out_illegal = r_illegal;
endmodule

// File: tb/tb_zba_issue_stage.sv
// Scoreboard bench for zba_issue_stage: directed plan items, then randomized traffic
// checked against an architectural model (register array + one-deep issue queue).
module tb_zba_issue_stage;
  localparam int XLEN = 64;

  typedef struct {
    logic [XLEN-1:0] rs1v, rs2v, pc;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic            ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zba_issue_if #(.XLEN(XLEN)) bus ();
  zba_issue_stage #(.XLEN(XLEN), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [XLEN-1:0] mrf [32];
  exp_t            q[$];
  int              n_chk = 0;
  int              n_fail = 0;
  bit              mon_en = 1'b0;

  function automatic logic [31:0] enc(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] shadd(logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2);
    return enc(7'b0010000, rs2, rs1, f3, rd, 7'b0110011);
  endfunction

  function automatic logic [XLEN-1:0] rdreg(logic [4:0] idx);
    return (idx == 5'd0) ? '0 : mrf[idx];
  endfunction

  // One clock of stimulus; afterwards the model absorbs what the DUT took at the edge.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                      input bit we, input logic [4:0] wrd, input logic [XLEN-1:0] wd,
                      input bit ordy, input bit fl);
    bit   acc, stall;
    exp_t e;
    bus.in_valid = iv;  bus.in_instr = ins;  bus.in_pc = pc;
    bus.wb_en = we;     bus.wb_rd = wrd;     bus.wb_data = wd;
    bus.out_ready = ordy; bus.flush = fl;
    acc   = iv && (q.size() == 0 || ordy);
    stall = (q.size() != 0) && !ordy;
    @(posedge clk);
    #1;
    if (we && wrd != 5'd0) mrf[wrd] = wd;
    if (fl) q.delete();
    else if (acc) begin
      e.rs1  = ins[19:15];  e.rs2 = ins[24:20];
      e.rs1v = rdreg(e.rs1); e.rs2v = rdreg(e.rs2);
      e.pc = pc; e.f3 = ins[14:12]; e.rd = ins[11:7];
      e.ill = !(ins[6:0] == 7'h33 && ins[31:25] == 7'h10 &&
                (ins[14:12] == 3'd2 || ins[14:12] == 3'd4 || ins[14:12] == 3'd6));
      q.push_back(e);
    end else if (stall && we && wrd != 5'd0) begin
      if (wrd == q[0].rs1) q[0].rs1v = wd;
      if (wrd == q[0].rs2) q[0].rs2v = wd;
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 32'h0, '0, 1'b0, 5'd0, '0, ordy, 1'b0);
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() != 0});
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, (q.size() == 0) || bus.out_ready});
      if (bus.out_valid && q.size() != 0) begin
        n_chk++;
        if (bus.out_rs1_val !== q[0].rs1v || bus.out_rs2_val !== q[0].rs2v ||
            bus.out_funct3 !== q[0].f3 || bus.out_rd !== q[0].rd ||
            bus.out_pc !== q[0].pc || bus.out_illegal !== q[0].ill) begin
          n_fail++;
          $display("FAIL issue_fields: got rs1=%0h rs2=%0h f3=%0d rd=%0d pc=%0h ill=%0b expected rs1=%0h rs2=%0h f3=%0d rd=%0d pc=%0h ill=%0b",
                   bus.out_rs1_val, bus.out_rs2_val, bus.out_funct3, bus.out_rd, bus.out_pc,
                   bus.out_illegal, q[0].rs1v, q[0].rs2v, q[0].f3, q[0].rd, q[0].pc, q[0].ill);
        end
        if (bus.out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    int          cnt;
    logic [31:0] ins;
    logic [2:0]  f3s [3];
    f3s[0] = 3'd2; f3s[1] = 3'd4; f3s[2] = 3'd6;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.flush = 0;
    bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.out_ready = 0;

    #3;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_rs1_val", bus.out_rs1_val, 64'd0);
    chk("rst_rs2_val", bus.out_rs2_val, 64'd0);
    chk("rst_pc", bus.out_pc, 64'd0);
    chk("rst_rd_f3_ill", {55'd0, bus.out_rd, bus.out_funct3, bus.out_illegal}, 64'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Basic SH2ADD x7,x5,x6
    step(0, 0, 0, 1, 5'd5, 64'h10, 1, 0);
    step(0, 0, 0, 1, 5'd6, 64'h3, 1, 0);
    step(1, 32'h2062C3B3, 64'h1000, 0, 0, 0, 1, 0);
    idle(1);
    chk("sh2add_issued", {63'd0, bus.out_valid}, 64'd0);

    // x0 never writable and always reads 0
    step(1, shadd(3'd2, 5'd8, 5'd0, 5'd6), 64'h1004, 1, 5'd0, 64'hFFFF, 1, 0);
    step(1, shadd(3'd4, 5'd9, 5'd6, 5'd0), 64'h1008, 0, 0, 0, 1, 0);
    idle(1);

    // Same-cycle bypass, then stall refresh of rs2
    step(1, shadd(3'd2, 5'd10, 5'd5, 5'd6), 64'h100C, 1, 5'd5, 64'hAA, 0, 0);
    step(0, 0, 0, 1, 5'd6, 64'h55, 0, 0);
    chk("refresh_rs2", bus.out_rs2_val, 64'h55);
    chk("bypass_rs1", bus.out_rs1_val, 64'hAA);
    step(0, 0, 0, 1, 5'd5, 64'hBB, 0, 0);
    idle(1);

    // Streaming with out_ready high, then a blocked stream
    for (int i = 0; i < 4; i++)
      step(1, shadd(f3s[i % 3], 5'(11 + i), 5'd5, 5'd6), 64'h2000 + 64'(4 * i), 0, 0, 0, 1, 0);
    idle(1);
    for (int i = 0; i < 4; i++)
      step(1, shadd(3'd6, 5'(15 + i), 5'd6, 5'd5), 64'h3000 + 64'(4 * i), 0, 0, 0, 0, 0);
    chk("blocked_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("blocked_pc", bus.out_pc, 64'h3000);
    idle(1);

    // Illegal encodings still issue; SH3ADD is legal
    step(1, enc(7'd0, 5'd6, 5'd5, 3'd0, 5'd1, 7'h33), 64'h4000, 0, 0, 0, 1, 0);
    chk("add_illegal", {63'd0, bus.out_illegal}, 64'd1);
    step(1, enc(7'h10, 5'd6, 5'd5, 3'd1, 5'd2, 7'h33), 64'h4004, 0, 0, 0, 1, 0);
    step(1, shadd(3'd6, 5'd3, 5'd5, 5'd6), 64'h4008, 0, 0, 0, 1, 0);
    chk("sh3add_legal", {60'd0, bus.out_funct3, bus.out_illegal}, {60'd0, 3'b110, 1'b0});
    idle(1);

    // Flush drops an accept; also flush of a held instruction with a writeback
    step(1, shadd(3'd2, 5'd4, 5'd5, 5'd6), 64'h5000, 0, 0, 0, 1, 1);
    chk("flush_drop", {63'd0, bus.out_valid}, 64'd0);
    step(1, shadd(3'd2, 5'd4, 5'd5, 5'd6), 64'h5004, 0, 0, 0, 0, 0);
    step(1, shadd(3'd4, 5'd4, 5'd7, 5'd6), 64'h5008, 1, 5'd7, 64'h77, 0, 1);
    step(1, shadd(3'd4, 5'd4, 5'd7, 5'd6), 64'h500C, 0, 0, 0, 1, 0);
    idle(1);

    // Asynchronous reset in the middle of a stall
    step(1, shadd(3'd2, 5'd4, 5'd5, 5'd6), 64'h6000, 0, 0, 0, 0, 0);
    idle(0);
    #2; rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    q.delete();
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    bus.in_valid = 0; bus.wb_en = 0; bus.flush = 0;
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, shadd(3'd2, 5'd4, 5'd5, 5'd6), 64'h6004, 0, 0, 0, 1, 0);
    chk("post_rst_regs_zero", bus.out_rs1_val | bus.out_rs2_val, 64'd0);
    step(1, shadd(3'd4, 5'd4, 5'd7, 5'd3), 64'h6008, 0, 0, 0, 1, 0);
    idle(1);

    // Randomized traffic
    cnt = 0;
    repeat (600) begin
      if ($urandom_range(0, 4) == 0)
        ins = $urandom();
      else
        ins = shadd(f3s[$urandom_range(0, 2)], 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step($urandom_range(0, 3) != 0, ins, {$urandom(), $urandom()},
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), {$urandom(), $urandom()},
           $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      cnt++;
    end
    repeat (3) idle(1);
    chk("drain_empty", 64'(q.size()), 64'd0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/zba_issue_stage.md
Name: zba_issue_stage

Overview:
- Decode/operand-fetch stage directly upstream of the Zba execute unit.
- Accepts a 32-bit instruction and decodes SH1ADD/SH2ADD/SH3ADD.
- Reads rs1/rs2 from an internal 32x64 register file that is written by the writeback port.
- Presents registered operands, funct3 and rd to the execute unit over a valid/ready handshake. It is a single pipeline register with stall-time operand refresh.

Parameters:
- XLEN, 64, operand/register width
- NREGS, 32, architectural register count; index width is 5 bits

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept an instruction
- in_instr  input  32  instruction word
- in_pc  input  XLEN  instruction PC
- wb_en  input  1  writeback enable
- wb_rd  input  5  writeback destination index
- wb_data  input  XLEN  writeback value
- out_valid  output  1  issue slot holds an instruction
- out_ready  input  1  execute unit accepts
- out_rs1_val  output  XLEN  rs1 operand
- out_rs2_val  output  XLEN  rs2 operand
- out_funct3  output  3  funct3 passed to execute (010/100/110)
- out_rd  output  5  destination index
- out_pc  output  XLEN  PC of the issued instruction
- out_illegal  output  1  instruction is not a legal Zba sh*add

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: all register-file entries 0; out_valid=0; out_rs1_val=0; out_rs2_val=0; out_funct3=0; out_rd=0; out_pc=0; out_illegal=0; internal held rs1/rs2 indices=0.
- Field extraction:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
  - Legal when opcode==7'b0110011, funct7==7'b0010000 and funct3 is one of 010, 100, 110.
  - Otherwise out_illegal=1; the fields and operands are still captured as decoded.
- Register file:
  - Write when wb_en && wb_rd!=0. Writes to x0 are ignored.
  - Reads of x0 return 0.
- Same-cycle bypass: if wb_en && wb_rd!=0 && wb_rd==rs1 (or rs2), the captured operand is wb_data, not the stale array value.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
  - Issue = out_valid && out_ready.
  - On accept, all out_* fields are registered next edge and out_valid=1. One-cycle latency, instr to out.
  - Issue without accept clears out_valid. Issue with accept is back-to-back: out_valid stays 1 with the new contents.
  - out_* fields are stable while out_valid && !out_ready.
- Stall refresh: while out_valid && !out_ready, a writeback with wb_en && wb_rd!=0 matching the held rs1 (rs2) index overwrites out_rs1_val (out_rs2_val) with wb_data next edge. Both operands update if both indices match.
- Flush:
  - Next edge out_valid=0; any accept in that cycle is dropped.
  - The writeback still commits to the register file.
  - flush has priority over accept and refresh.
- Throughput: one instruction per cycle when out_ready is held high.
- Mid-operation reset: asserting rst_n low clears out_valid and the register file immediately, independent of clk.

Test Plan:
- Reset, then write x5=0x10 and x6=0x3; issue SH2ADD x7,x5,x6 (0x2062C3B3) -> next cycle out_valid=1, rs1_val=0x10, rs2_val=0x3, funct3=100, rd=7, illegal=0.
- Issue with rs1=x0 while wb writes x0=0xFFFF -> rs1_val=0; a later read of x0 still returns 0.
- Same-cycle bypass: wb x5=0xAA in the cycle SH1ADD reads x5 -> rs1_val=0xAA. Stall refresh: hold out_ready=0, wb x6=0x55 -> out_rs2_val becomes 0x55; other fields unchanged.
- Stream 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles, in_ready constantly 1. With out_ready=0 -> in_ready=0 from cycle 2 and the first instruction is held stable.
- Plain ADD (funct7=0) and funct3=001 with funct7=0010000 -> out_illegal=1, out_valid=1. SH3ADD -> funct3=110, illegal=0.
- Flush with in_valid=1 -> next cycle out_valid=0 and the instruction is not issued. rst_n low mid-stall -> out_valid=0 immediately, and all registers read 0 after release.
